// File: rtl/jtpopeye_bck_scroll_if.sv
// Background-layer CPU bus: nibble RMW write port plus the scroll/palette
// staging register port.
//   cpu_wr    one-cycle nibble write strobe
//   cpu_addr  [AW] nibble select, [AW-1:0] byte address
//   cpu_din   write data (low nibble for nibble 0, high nibble for nibble 1)
//   busy      read-modify-write in progress (driven by the layer)
//   scr_we    staging register write strobe
//   scr_sel   0 scroll_x, 1 scroll_y, 2 palette bank, 3 ignored
//   scr_din   staging register data
interface jtpopeye_bck_scroll_if #(parameter int AW = 12);
    logic          cpu_wr;
    logic [AW:0]   cpu_addr;
    logic [7:0]    cpu_din;
    logic          busy;
    logic          scr_we;
    logic [1:0]    scr_sel;
    logic [7:0]    scr_din;

    modport master (output cpu_wr, cpu_addr, cpu_din, scr_we, scr_sel, scr_din,
                    input  busy);
    modport slave  (input  cpu_wr, cpu_addr, cpu_din, scr_we, scr_sel, scr_din,
                    output busy);
endinterface

// File: rtl/jtpopeye_bck_scroll.sv
// Popeye background layer: nibble-packed background RAM with hardware scroll
// and palette-bank selection. Video fetches own the single RAM port on
// pxl_cen cycles; CPU nibble writes run as read-modify-write sequences in the
// idle cycles between them.
//   clk, rst_n      system clock, asynchronous active-low reset
//   bus             CPU write port and scroll/palette staging port (slave)
//   pxl_cen         pixel clock enable, never high on consecutive cycles
//   hpos, vpos      raster position of the pixel being fetched
//   vs, blank       vertical sync, blanking
//   bakc            background colour {palette bank, nibble}
module jtpopeye_bck_scroll #(
    parameter int AW   = 12,
    parameter int HB   = 6,
    parameter int BLK  = 3,
    parameter int BLKV = 2,
    parameter int CW   = 5
)(
    input  logic                 clk,
    input  logic                 rst_n,
    jtpopeye_bck_scroll_if.slave bus,
    input  logic                 pxl_cen,
    input  logic [8:0]           hpos,
    input  logic [8:0]           vpos,
    input  logic                 vs,
    input  logic                 blank,
    output logic [CW-1:0]        bakc
);
    localparam int VB = AW - HB;
    localparam int XW = BLK + HB + 1;
    localparam int YW = BLKV + VB;
    localparam int PW = CW - 4;

    typedef enum logic [1:0] {IDLE, RD, LAT, WR} state_t;

    logic [7:0]    mem [0:2**AW-1];
    logic [7:0]    q;
    logic [AW-1:0] ram_addr;
    logic          ram_we;
    logic [7:0]    ram_wdata;

    logic [7:0]    scroll_x_stg, scroll_y_stg, scroll_x_act, scroll_y_act;
    logic [PW-1:0] pal_stg, pal_act;
    logic          vs_d;
    logic          vs_rise;

    logic [XW-1:0] x_eff;
    logic [YW-1:0] y_eff;
    logic [AW-1:0] vid_addr;

    logic          cen_d, nib_sel, blank_d, cap_blank;
    logic [3:0]    cap_nib;

    state_t        state_q, state_d;
    logic [AW:0]   lat_addr;
    logic [7:0]    lat_din;
    logic [7:0]    old;
    logic [AW-1:0] cpu_byte;

    logic          unused_bits;

    assign vs_rise     = vs & ~vs_d;
    assign x_eff       = XW'(hpos) + XW'(scroll_x_act);
    assign y_eff       = YW'(vpos) + YW'(scroll_y_act);
    assign vid_addr    = {y_eff[YW-1:BLKV], x_eff[BLK+HB-1:BLK]};
    assign cpu_byte    = lat_addr[AW-1:0];
    assign ram_wdata   = lat_addr[AW] ? {lat_din[7:4], old[3:0]}
                                      : {old[7:4], lat_din[3:0]};
    assign bus.busy    = (state_q != IDLE);
    assign unused_bits = ^{vpos, x_eff[BLK-1:0], y_eff[BLKV-1:0]};

    // Single-port RAM, read-first; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        q <= mem[ram_addr];
    end

    // Staging writes always land in staging; the active set picks up the
    // pre-write staged values on the first cycle vs is seen high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_d         <= 1'b0;
            scroll_x_stg <= '0;
            scroll_y_stg <= '0;
            pal_stg      <= '0;
            scroll_x_act <= '0;
            scroll_y_act <= '0;
            pal_act      <= '0;
        end else begin
            vs_d <= vs;
            if (vs_rise) begin
                scroll_x_act <= scroll_x_stg;
                scroll_y_act <= scroll_y_stg;
                pal_act      <= pal_stg;
            end
            if (bus.scr_we) begin
                case (bus.scr_sel)
                    2'd0:    scroll_x_stg <= bus.scr_din;
                    2'd1:    scroll_y_stg <= bus.scr_din;
                    2'd2:    pal_stg      <= bus.scr_din[PW-1:0];
                    default: ;
                endcase
            end
        end
    end

    // Video pipeline: fetch on pxl_cen, capture q one cycle later (always a
    // non-cen cycle, so q still holds the video read), present on next pxl_cen.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cen_d     <= 1'b0;
            nib_sel   <= 1'b0;
            blank_d   <= 1'b1;
            cap_nib   <= 4'd0;
            cap_blank <= 1'b1;
            bakc      <= '0;
        end else begin
            cen_d <= pxl_cen;
            if (pxl_cen) begin
                nib_sel <= x_eff[XW-1];
                blank_d <= blank;
                bakc    <= cap_blank ? '0 : {pal_act, cap_nib};
            end
            if (cen_d) begin
                cap_nib   <= nib_sel ? q[7:4] : q[3:0];
                cap_blank <= blank_d;
            end
        end
    end

    // CPU FSM state register plus the latched request and the old byte read
    // back during LAT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            lat_addr <= '0;
            lat_din  <= '0;
            old      <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && bus.cpu_wr) begin
                lat_addr <= bus.cpu_addr;
                lat_din  <= bus.cpu_din;
            end
            if (state_q == LAT) old <= q;
        end
    end

    // Next state: RD and WR wait out pxl_cen cycles, LAT is a fixed single cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.cpu_wr) state_d = RD;
            RD:      if (!pxl_cen)   state_d = LAT;
            LAT:                     state_d = WR;
            WR:      if (!pxl_cen)   state_d = IDLE;
            default:                 state_d = IDLE;
        endcase
    end

    // RAM port ownership: CPU only takes the port on non-cen RD/WR cycles.
    always_comb begin
        ram_addr = vid_addr;
        ram_we   = 1'b0;
        case (state_q)
            RD: if (!pxl_cen) ram_addr = cpu_byte;
            WR: if (!pxl_cen) begin
                    ram_addr = cpu_byte;
                    ram_we   = 1'b1;
                end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_jtpopeye_bck_scroll.sv
// Self-checking bench for jtpopeye_bck_scroll: a reference model of the
// background layer pushes expected colours into a queue on every pixel fetch;
// a monitor pops and compares on each pxl_cen output update.
module tb_jtpopeye_bck_scroll;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       pxl_cen;
    logic [8:0] hpos, vpos;
    logic       vs, blank;
    logic [4:0] bakc;

    jtpopeye_bck_scroll_if #(.AW(12)) bus();

    jtpopeye_bck_scroll dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus.slave),
        .pxl_cen (pxl_cen),
        .hpos    (hpos),
        .vpos    (vpos),
        .vs      (vs),
        .blank   (blank),
        .bakc    (bakc)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic skip; logic blank; logic [3:0] nib; } rec_t;
    typedef struct packed { logic skip; logic [4:0] val; } exp_t;

    int   errors = 0;
    int   checks = 0;

    // reference model state
    logic [7:0] m_mem   [0:4095];
    logic [1:0] m_known [0:4095];
    int         m_sx_stg, m_sy_stg, m_pal_stg, m_sx_act, m_sy_act, m_pal_act;
    logic       m_vs_prev;
    rec_t       prev_rec;
    exp_t       exp_q[$];
    logic       pend_valid = 1'b0;
    int         pend_addr  = 0;
    int         mx, my, ma, mn;
    logic       mrise;
    exp_t       pushed, popped;

    // video stimulus controls
    int         cen_mode  = 1;
    logic       vid_fixed = 1'b0;
    logic [8:0] fix_h = '0, fix_v = '0;
    logic       fix_blank = 1'b0;

    initial begin
        for (int i = 0; i < 4096; i++) begin
            m_mem[i]   = 8'h00;
            m_known[i] = 2'b00;
        end
    end

    // Reference model: pixel address from the scroll rules, staged/active regs.
    always @(posedge clk) begin
        if (!rst_n) begin
            m_sx_stg = 0; m_sy_stg = 0; m_pal_stg = 0;
            m_sx_act = 0; m_sy_act = 0; m_pal_act = 0;
            m_vs_prev = 1'b0;
            prev_rec  = '{skip: 1'b0, blank: 1'b1, nib: 4'd0};
            exp_q.delete();
        end else begin
            mrise     = vs && !m_vs_prev;
            m_vs_prev = vs;
            if (pxl_cen) begin
                pushed.skip = prev_rec.skip;
                pushed.val  = prev_rec.blank ? 5'd0 : {1'(m_pal_act), prev_rec.nib};
                exp_q.push_back(pushed);
                mx = (int'(hpos) + m_sx_act) % 1024;
                my = (int'(vpos) + m_sy_act) % 256;
                ma = (my / 4) * 64 + (mx / 8) % 64;
                mn = mx / 512;
                prev_rec.blank = blank;
                prev_rec.nib   = (mn == 1) ? m_mem[ma][7:4] : m_mem[ma][3:0];
                prev_rec.skip  = !blank && (!m_known[ma][mn] || (pend_valid && pend_addr == ma));
            end
            if (mrise) begin
                m_sx_act = m_sx_stg; m_sy_act = m_sy_stg; m_pal_act = m_pal_stg;
            end
            if (bus.scr_we) begin
                case (bus.scr_sel)
                    2'd0: m_sx_stg  = int'(bus.scr_din);
                    2'd1: m_sy_stg  = int'(bus.scr_din);
                    2'd2: m_pal_stg = int'(bus.scr_din[0]);
                    default: ;
                endcase
            end
        end
    end

    // Monitor: every pxl_cen output update is compared against the queue.
    always @(posedge clk) begin
        if (rst_n && pxl_cen) begin
            @(negedge clk);
            if (exp_q.size() == 0) begin
                checks++; errors++;
                $display("[TB] FAIL bakc_queue: output update with no expected value at %0t", $time);
            end else begin
                popped = exp_q.pop_front();
                if (!popped.skip) begin
                    checks++;
                    if (bakc !== popped.val) begin
                        errors++;
                        $display("[TB] FAIL bakc: got %h expected %h at %0t", bakc, popped.val, $time);
                    end
                end
            end
        end
    end

    // Video driver: pixel enable pattern and raster position, 1 ns after the edge.
    initial begin
        pxl_cen = 1'b0; hpos = '0; vpos = '0; blank = 1'b0;
        forever begin
            @(posedge clk); #1;
            case (cen_mode)
                0:       pxl_cen = 1'b0;
                1:       pxl_cen = !pxl_cen;
                default: pxl_cen = pxl_cen ? 1'b0 : ($urandom_range(0, 1) == 1);
            endcase
            if (vid_fixed) begin
                hpos = fix_h; vpos = fix_v; blank = fix_blank;
            end else begin
                hpos  = 9'($urandom_range(0, 511));
                vpos  = 9'($urandom_range(0, 7)) | (9'($urandom_range(0, 1)) << 8);
                blank = ($urandom_range(0, 7) == 0);
            end
        end
    end

    task automatic tick();
        @(posedge clk); #2;
    endtask

    task automatic check_val(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 40; i++) begin
            if (!bus.busy) break;
            tick();
        end
        if (bus.busy) begin
            checks++; errors++;
            $display("[TB] FAIL busy_timeout: got 1 expected 0 at %0t", $time);
        end
        pend_valid = 1'b0;
    endtask

    task automatic model_write(input logic [12:0] a, input logic [7:0] d);
        int b;
        b = int'(a[11:0]);
        if (a[12]) begin
            m_mem[b][7:4] = d[7:4]; m_known[b][1] = 1'b1;
        end else begin
            m_mem[b][3:0] = d[3:0]; m_known[b][0] = 1'b1;
        end
        pend_valid = 1'b1;
        pend_addr  = b;
    endtask

    // Accepted nibble write; reports how many cycles busy stayed high.
    task automatic cpu_write(input logic [12:0] a, input logic [7:0] d, output int nbusy);
        wait_idle();
        bus.cpu_wr = 1'b1; bus.cpu_addr = a; bus.cpu_din = d;
        model_write(a, d);
        tick();
        bus.cpu_wr = 1'b0;
        nbusy = 0;
        for (int i = 0; i < 40; i++) begin
            if (!bus.busy) break;
            nbusy++;
            tick();
        end
        wait_idle();
    endtask

    task automatic scr_write(input logic [1:0] sel, input logic [7:0] d);
        bus.scr_we = 1'b1; bus.scr_sel = sel; bus.scr_din = d;
        tick();
        bus.scr_we = 1'b0;
    endtask

    task automatic vs_pulse();
        vs = 1'b1;
        repeat (3) tick();
        vs = 1'b0;
        tick();
    endtask

    task automatic probe(input logic [8:0] h, input logic [8:0] v, input logic b, input int n);
        vid_fixed = 1'b1; fix_h = h; fix_v = v; fix_blank = b;
        repeat (n) tick();
    endtask

    task automatic align_cen();
        for (int i = 0; i < 4; i++) begin
            if (pxl_cen) break;
            tick();
        end
        tick();
    endtask

    initial begin
        #900000;
        $display("[TB] FAIL watchdog: simulation did not finish at %0t", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int nb;
        logic [12:0] ra;
        rst_n = 1'b0; vs = 1'b0;
        bus.cpu_wr = 1'b0; bus.cpu_addr = '0; bus.cpu_din = '0;
        bus.scr_we = 1'b0; bus.scr_sel = '0; bus.scr_din = '0;
        cen_mode = 1;
        repeat (6) tick();
        check_val("reset_bakc", 8'(bakc), 8'd0);
        check_val("reset_busy", 8'(bus.busy), 8'd0);
        rst_n = 1'b1;
        repeat (6) tick();

        // preload rows 0 and 1 with random bytes under random video traffic
        cen_mode = 2;
        for (int a = 0; a < 128; a++) begin
            cpu_write({1'b0, 12'(a)}, 8'($urandom_range(0, 255)), nb);
            cpu_write({1'b1, 12'(a)}, 8'($urandom_range(0, 255)), nb);
        end

        // nibble RMW on byte 0x005 with video idle
        cen_mode = 0;
        tick(); tick();
        cpu_write(13'h0005, 8'h03, nb);
        cpu_write(13'h1005, 8'hA0, nb);
        cpu_write(13'h1005, 8'h70, nb);
        check_val("rmw_busy_hi", 8'(nb), 8'd3);
        cpu_write(13'h0005, 8'h0C, nb);
        check_val("rmw_busy_lo", 8'(nb), 8'd3);
        cen_mode = 1;
        probe(9'd40, 9'd0, 1'b0, 8);

        // contention: RD meets pxl_cen
        vid_fixed = 1'b0;
        align_cen();
        cpu_write(13'h1006, 8'h50, nb);
        check_val("cont_busy_hi", 8'(nb), 8'd4);
        align_cen();
        cpu_write(13'h0006, 8'h01, nb);
        check_val("cont_busy_lo", 8'(nb), 8'd4);
        probe(9'd48, 9'd0, 1'b0, 8);

        // overrun: second strobe one cycle later is dropped
        cen_mode = 0;
        tick(); tick();
        bus.cpu_wr = 1'b1; bus.cpu_addr = 13'h0010; bus.cpu_din = 8'h0E;
        model_write(13'h0010, 8'h0E);
        tick();
        bus.cpu_addr = 13'h0011; bus.cpu_din = 8'h0F;
        tick();
        bus.cpu_wr = 1'b0;
        wait_idle();
        // strobe in the WR cycle, while busy is still high, is dropped too
        bus.cpu_wr = 1'b1; bus.cpu_addr = 13'h0012; bus.cpu_din = 8'h09;
        model_write(13'h0012, 8'h09);
        tick();
        bus.cpu_wr = 1'b0;
        tick(); tick();
        bus.cpu_wr = 1'b1; bus.cpu_addr = 13'h0013; bus.cpu_din = 8'h06;
        tick();
        bus.cpu_wr = 1'b0;
        check_val("busy_fall", 8'(bus.busy), 8'd0);
        tick();
        check_val("drop_at_fall", 8'(bus.busy), 8'd0);
        wait_idle();
        cen_mode = 1;
        probe(9'd128, 9'd0, 1'b0, 6);
        probe(9'd136, 9'd0, 1'b0, 6);
        probe(9'd144, 9'd0, 1'b0, 6);
        probe(9'd152, 9'd0, 1'b0, 6);

        // scroll/bank staging only takes effect on vs
        probe(9'd0, 9'd0, 1'b0, 4);
        scr_write(2'd0, 8'd8);
        scr_write(2'd2, 8'd1);
        scr_write(2'd3, 8'd77);
        probe(9'd0, 9'd0, 1'b0, 8);
        vs_pulse();
        probe(9'd0, 9'd0, 1'b0, 8);
        // staging write on the vs rising cycle stays in staging
        vs = 1'b1;
        scr_write(2'd2, 8'd0);
        vs = 1'b0;
        probe(9'd0, 9'd0, 1'b0, 6);
        vs_pulse();
        probe(9'd0, 9'd0, 1'b0, 6);

        // high nibble of 0x005 via scroll, then wrap-around and blanking
        scr_write(2'd0, 8'h80);
        vs_pulse();
        probe(9'd424, 9'd0, 1'b0, 6);
        scr_write(2'd0, 8'd1);
        scr_write(2'd1, 8'd1);
        vs_pulse();
        probe(9'h1FF, 9'h0FF, 1'b0, 6);
        probe(9'h1FF, 9'h0FF, 1'b1, 6);
        probe(9'h1FF, 9'h0FF, 1'b0, 6);

        // randomized mixed traffic
        vid_fixed = 1'b0;
        for (int it = 0; it < 40; it++) begin
            cen_mode = 2;
            case ($urandom_range(0, 3))
                0: scr_write(2'd0, 8'($urandom_range(0, 255)));
                1: scr_write(2'd1, 8'($urandom_range(0, 3)));
                2: scr_write(2'($urandom_range(2, 3)), 8'($urandom_range(0, 255)));
                default: vs_pulse();
            endcase
            repeat ($urandom_range(1, 4)) begin
                ra     = 13'($urandom_range(0, 127));
                ra[12] = 1'($urandom_range(0, 1));
                cpu_write(ra, 8'($urandom_range(0, 255)), nb);
            end
            repeat ($urandom_range(2, 10)) tick();
        end

        cen_mode = 0;
        repeat (6) tick();
        if (exp_q.size() > 1) begin
            checks++; errors++;
            $display("[TB] FAIL queue_drain: got %0d pending expected at most 1", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
